// File: rtl/ahb_bus_matrix_wrr_arbiter.sv
// ahb_bus_matrix_wrr_arbiter: weighted round-robin output-stage arbiter, switching only at transfer boundaries
module ahb_bus_matrix_wrr_arbiter #(
    parameter bit BURST_HOLD = 1'b1,
    parameter int CREDIT_W   = 4
) (
    input  logic                HCLK,
    input  logic                HRESET,
    input  logic                req_port0,
    input  logic                req_port1,
    input  logic                req_port2,
    input  logic                req_port3,
    input  logic [CREDIT_W-1:0] weight_port0,
    input  logic [CREDIT_W-1:0] weight_port1,
    input  logic [CREDIT_W-1:0] weight_port2,
    input  logic [CREDIT_W-1:0] weight_port3,
    input  logic                HREADYM,
    input  logic                HSELM,
    input  logic [1:0]          HTRANSM,
    input  logic [2:0]          HBURSTM,
    input  logic                HMASTLOCKM,
    output logic [1:0]          addr_in_port,
    output logic                no_port,
    output logic [CREDIT_W-1:0] credit_left
);
    logic [3:0]          req;
    logic [CREDIT_W-1:0] weight [4];
    logic [3:0]          beat, beat_nxt, beat_load;
    logic [1:0]          last, win;
    logic                found, acc, hold;
    logic [CREDIT_W-1:0] credit_dec, credit_load;

    assign req       = {req_port3, req_port2, req_port1, req_port0};
    assign weight[0] = weight_port0;
    assign weight[1] = weight_port1;
    assign weight[2] = weight_port2;
    assign weight[3] = weight_port3;
    assign acc       = HSELM & HTRANSM[1];

    // remaining beats of a fixed-length burst, counted on accepted beats
    always_comb begin
        beat_load = (HBURSTM == 3'd2 || HBURSTM == 3'd3) ? 4'd3 :
                    (HBURSTM == 3'd4 || HBURSTM == 3'd5) ? 4'd7 :
                    (HBURSTM == 3'd6 || HBURSTM == 3'd7) ? 4'd15 : 4'd0;
        beat_nxt  = !BURST_HOLD                 ? 4'd0 :
                    (acc && HTRANSM == 2'b10)   ? beat_load :
                    (acc && HTRANSM == 2'b11)   ? (beat == 4'd0 ? 4'd0 : beat - 4'd1) : beat;
    end

    // round-robin search from the port after the last owner; owner keeps grant on lock, burst or credit
    always_comb begin
        found = 1'b0;
        win   = last;
        for (int i = 1; i <= 4; i++) begin
            if (!found && req[2'(last + 2'(i))]) begin
                found = 1'b1;
                win   = 2'(last + 2'(i));
            end
        end
        credit_dec  = (acc && credit_left != '0) ? credit_left - CREDIT_W'(1) : credit_left;
        credit_load = (weight[win] == '0) ? CREDIT_W'(1) : weight[win];
        hold        = HMASTLOCKM | (beat_nxt != 4'd0) |
                      (req[addr_in_port] & !no_port & (credit_dec != '0));
    end

    // grant state advances only when the address phase completes
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            addr_in_port <= 2'd0;
            no_port      <= 1'b1;
            credit_left  <= '0;
            beat         <= 4'd0;
            last         <= 2'd0;
        end else if (HREADYM) begin
            if (hold) begin
                credit_left <= credit_dec;
                beat        <= beat_nxt;
            end else if (found) begin
                addr_in_port <= win;
                no_port      <= 1'b0;
                last         <= win;
                credit_left  <= credit_load;
                beat         <= 4'd0;
            end else begin
                no_port     <= 1'b1;
                credit_left <= '0;
                beat        <= 4'd0;
            end
        end
    end
endmodule

// File: tb/tb_ahb_bus_matrix_wrr_arbiter.sv
// tb_ahb_bus_matrix_wrr_arbiter: table-driven check of the weighted round-robin arbiter
module tb_ahb_bus_matrix_wrr_arbiter;
    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [15:0] w;
        logic        rdy;
        logic        sel;
        logic [1:0]  tr;
        logic [2:0]  bu;
        logic        lk;
        logic [1:0]  ep;
        logic        enp;
        logic [3:0]  ecr;
    } vec_t;

    localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, NS = 2'd2, SQ = 2'd3;
    localparam logic [15:0] WA = 16'h2153, WC = 16'h2151, WE = 16'h2103;

    logic        HCLK = 1'b0, HRESET = 1'b1, HREADYM = 1'b1, HSELM = 1'b1, HMASTLOCKM = 1'b0;
    logic [3:0]  req = 4'd0;
    logic [15:0] w = WA;
    logic [1:0]  HTRANSM = IDLE;
    logic [2:0]  HBURSTM = 3'd0;
    logic [1:0]  port0, port1;
    logic        np0, np1;
    logic [3:0]  cr0, cr1;
    vec_t        tv[$];
    int          nvec = 0, nfail = 0;

    always #5 HCLK = ~HCLK;

    ahb_bus_matrix_wrr_arbiter #(.BURST_HOLD(1'b1), .CREDIT_W(4)) u0 (
        .HCLK(HCLK), .HRESET(HRESET),
        .req_port0(req[0]), .req_port1(req[1]), .req_port2(req[2]), .req_port3(req[3]),
        .weight_port0(w[3:0]), .weight_port1(w[7:4]), .weight_port2(w[11:8]), .weight_port3(w[15:12]),
        .HREADYM(HREADYM), .HSELM(HSELM), .HTRANSM(HTRANSM), .HBURSTM(HBURSTM), .HMASTLOCKM(HMASTLOCKM),
        .addr_in_port(port0), .no_port(np0), .credit_left(cr0));

    ahb_bus_matrix_wrr_arbiter #(.BURST_HOLD(1'b0), .CREDIT_W(4)) u1 (
        .HCLK(HCLK), .HRESET(HRESET),
        .req_port0(req[0]), .req_port1(req[1]), .req_port2(req[2]), .req_port3(req[3]),
        .weight_port0(w[3:0]), .weight_port1(w[7:4]), .weight_port2(w[11:8]), .weight_port3(w[15:12]),
        .HREADYM(HREADYM), .HSELM(HSELM), .HTRANSM(HTRANSM), .HBURSTM(HBURSTM), .HMASTLOCKM(HMASTLOCKM),
        .addr_in_port(port1), .no_port(np1), .credit_left(cr1));

    task automatic add(input logic rst, input logic [3:0] rq, input logic [15:0] wt, input logic rdy,
                       input logic sel, input logic [1:0] tr, input logic [2:0] bu, input logic lk,
                       input logic [1:0] ep, input logic enp, input logic [3:0] ecr);
        vec_t v;
        v.rst = rst; v.req = rq; v.w = wt; v.rdy = rdy; v.sel = sel; v.tr = tr; v.bu = bu; v.lk = lk;
        v.ep = ep; v.enp = enp; v.ecr = ecr;
        tv.push_back(v);
    endtask

    task automatic drive(input logic rst, input logic [3:0] rq, input logic [15:0] wt,
                         input logic [1:0] tr, input logic [2:0] bu);
        HRESET = rst; req = rq; w = wt; HREADYM = 1'b1; HSELM = 1'b1; HTRANSM = tr; HBURSTM = bu; HMASTLOCKM = 1'b0;
        @(posedge HCLK);
        #1;
    endtask

    task automatic chk(input string name, input int got, input int exp);
        nvec++;
        if (got != exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    initial begin
        // reset with port1 requesting, then first grant and first debit
        add(1, 4'b0010, WA, 1, 1, IDLE, 0, 0, 0, 1, 0);
        add(1, 4'b0010, WA, 1, 1, IDLE, 0, 0, 0, 1, 0);
        add(0, 4'b0010, WA, 1, 1, IDLE, 0, 0, 1, 0, 5);
        add(0, 4'b0010, WA, 1, 1, NS,   0, 0, 1, 0, 4);
        // weighting: port0 weight 3, port2 weight 1
        add(1, 4'b0101, WA, 1, 1, NS, 0, 0, 0, 1, 0);
        add(0, 4'b0101, WA, 1, 1, NS, 0, 0, 2, 0, 1);
        add(0, 4'b0101, WA, 1, 1, NS, 0, 0, 0, 0, 3);
        add(0, 4'b0101, WA, 1, 1, NS, 0, 0, 0, 0, 2);
        add(0, 4'b0101, WA, 1, 1, NS, 0, 0, 0, 0, 1);
        add(0, 4'b0101, WA, 1, 1, NS, 0, 0, 2, 0, 1);
        add(0, 4'b0101, WA, 1, 1, NS, 0, 0, 0, 0, 3);
        add(0, 4'b0101, WA, 1, 1, NS, 0, 0, 0, 0, 2);
        // INCR4 burst holds grant through wait state and BUSY
        add(1, 4'b0001, WC, 1, 1, IDLE, 0, 0, 0, 1, 0);
        add(0, 4'b0001, WC, 1, 1, IDLE, 0, 0, 0, 0, 1);
        add(0, 4'b0011, WC, 1, 1, NS,   3, 0, 0, 0, 0);
        add(0, 4'b0011, WC, 1, 1, SQ,   3, 0, 0, 0, 0);
        add(0, 4'b0011, WC, 0, 1, SQ,   3, 0, 0, 0, 0);
        add(0, 4'b0011, WC, 1, 1, BUSY, 3, 0, 0, 0, 0);
        add(0, 4'b0011, WC, 1, 1, SQ,   3, 0, 0, 0, 0);
        add(0, 4'b0011, WC, 1, 1, SQ,   3, 0, 1, 0, 5);
        // lock with wait states; RR resumes after port3
        add(1, 4'b1000, WA, 1, 1, IDLE, 0, 0, 0, 1, 0);
        add(0, 4'b1000, WA, 1, 1, IDLE, 0, 0, 3, 0, 2);
        for (int i = 0; i < 5; i++) add(0, 4'b1111, WA, 0, 1, NS, 0, 1, 3, 0, 2);
        add(0, 4'b1111, WA, 1, 1, NS, 0, 1, 3, 0, 1);
        for (int i = 0; i < 5; i++) add(0, 4'b1111, WA, 1, 1, NS, 0, 1, 3, 0, 0);
        add(0, 4'b1111, WA, 1, 1, IDLE, 0, 0, 0, 0, 3);
        // idle/drop, zero weight, HSELM low, sole requester re-grant
        add(1, 4'b0100, WE, 1, 1, IDLE, 0, 0, 0, 1, 0);
        add(0, 4'b0100, WE, 1, 1, IDLE, 0, 0, 2, 0, 1);
        add(0, 4'b0000, WE, 1, 1, IDLE, 0, 0, 2, 1, 0);
        add(0, 4'b0010, WE, 1, 1, IDLE, 0, 0, 1, 0, 1);
        add(0, 4'b0010, WE, 1, 0, NS,   0, 0, 1, 0, 1);
        add(0, 4'b0010, WE, 1, 1, NS,   0, 0, 1, 0, 1);
        // reset in the middle of an INCR8
        add(1, 4'b0001, WA, 1, 1, IDLE, 0, 0, 0, 1, 0);
        add(0, 4'b0001, WA, 1, 1, IDLE, 0, 0, 0, 0, 3);
        add(0, 4'b0011, WA, 1, 1, NS,   5, 0, 0, 0, 2);
        add(0, 4'b0011, WA, 1, 1, SQ,   5, 0, 0, 0, 1);
        add(1, 4'b0011, WA, 1, 1, SQ,   5, 0, 0, 1, 0);
        add(0, 4'b0011, WA, 1, 1, IDLE, 0, 0, 1, 0, 5);
        add(0, 4'b0011, WA, 1, 1, IDLE, 0, 0, 1, 0, 5);

        for (int k = 0; k < tv.size(); k++) begin
            HRESET = tv[k].rst; req = tv[k].req; w = tv[k].w; HREADYM = tv[k].rdy; HSELM = tv[k].sel;
            HTRANSM = tv[k].tr; HBURSTM = tv[k].bu; HMASTLOCKM = tv[k].lk;
            @(posedge HCLK);
            #1;
            nvec++;
            if (port0 !== tv[k].ep || np0 !== tv[k].enp || cr0 !== tv[k].ecr) begin
                nfail++;
                $display("FAIL vec%0d: port=%0d no_port=%0d credit=%0d expected port=%0d no_port=%0d credit=%0d",
                         k, port0, np0, cr0, tv[k].ep, tv[k].enp, tv[k].ecr);
            end
        end

        // burst-aware versus burst-unaware instance on the same INCR4
        drive(1, 4'b0001, WC, IDLE, 0);
        drive(0, 4'b0001, WC, IDLE, 0);
        chk("grant_hold1", port0, 0);
        chk("grant_hold0", port1, 0);
        drive(0, 4'b0011, WC, NS, 3);
        chk("nonseq_hold1", port0, 0);
        chk("nonseq_hold0", port1, 1);
        chk("nonseq_credit_hold0", cr1, 5);
        drive(0, 4'b0011, WC, SQ, 3);
        chk("seq_hold1", port0, 0);
        chk("seq_hold0", port1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
